// File: rtl/ubrain_unary_pkg.sv
// ubrain_unary_pkg: shared types and helpers for the uBrain unary datapath.
//   state_e     : generator FSM states
//   BWID_DEF    : default binary width (period = 2^BWID_DEF cycles)
//   NCH_DEF     : default number of parallel streams
//   PERIOD      : default period length in cycles
//   period_of() : period length for an arbitrary width
//   bitrev()    : reverse the low w bits of a value (upper bits cleared)
package ubrain_unary_pkg;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } state_e;

  localparam int unsigned BWID_DEF = 8;
  localparam int unsigned NCH_DEF  = 3;
  localparam int unsigned PERIOD   = 32'd1 << BWID_DEF;

  function automatic int unsigned period_of(input int unsigned w);
    return 32'd1 << w;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
    logic [31:0] src;
    logic [31:0] r;
    src = v;
    r   = '0;
    // Shift LSBs of the source into the result LSB-first; after w steps the
    // original bit 0 lands at bit w-1.
    for (int unsigned i = 0; i < w; i++) begin
      r   = {r[30:0], src[0]};
      src = src >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/unary_bitstream_gen_rng.sv
// unary_rng_sobol1d: one-dimensional Sobol (van der Corput) sequence for one
// channel. The period counter is shared between channels and supplied by the
// parent; each channel adds its own phase offset before bit reversal, so every
// channel still visits each BWID-bit value exactly once per period.
// Ports:
//   cnt : in  BWID  shared period counter
//   rng : out BWID  bitrev((cnt + OFST) mod 2^BWID)
// Parameters:
//   BWID : value width
//   OFST : per-channel phase offset
module unary_rng_sobol1d
  import ubrain_unary_pkg::*;
#(
  parameter int unsigned BWID = BWID_DEF,
  parameter int unsigned OFST = 0
) (
  input  logic [BWID-1:0] cnt,
  output logic [BWID-1:0] rng
);

  localparam int unsigned   PER = period_of(BWID);
  localparam logic [BWID-1:0] OFS = BWID'(OFST % PER);

  logic [BWID-1:0] idx;

  always_comb begin
    idx = cnt + OFS;
    rng = BWID'(bitrev(32'(idx), BWID));
  end

endmodule

// File: rtl/unary_bitstream_gen.sv
// unary_bitstream_gen: binary-to-unary stream transmitter. Accepts NCH binary
// values through a valid/ready handshake and emits NCH parallel unary
// bitstreams of 2^BWID cycles each; stream k carries exactly thr(data[k]) ones.
// Ports:
//   clk      : in   clock
//   rst_n    : in   asynchronous active-low reset
//   i_valid  : in   i_data valid
//   i_ready  : out  new values accepted this cycle (combinational)
//   i_data   : in   NCH x BWID binary values
//   i_en     : in   stream enable; low stalls counter and output
//   o_bit    : out  NCH unary bits
//   o_valid  : out  o_bit meaningful this cycle
//   o_last   : out  final cycle of the current period
//   o_done   : out  one-cycle pulse after a period ends without reload
// Configuration:
//   UBSG_BIPOLAR_EN : treat i_data as signed two's complement (bipolar);
//                     undefined gives unsigned unipolar encoding.
module unary_bitstream_gen
  import ubrain_unary_pkg::*;
#(
  parameter int unsigned BWID = BWID_DEF,
  parameter int unsigned NCH  = NCH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [BWID-1:0] i_data [NCH-1:0],
  input  logic            i_en,
  output logic            o_bit  [NCH-1:0],
  output logic            o_valid,
  output logic            o_last,
  output logic            o_done
);

  localparam int unsigned PER  = period_of(BWID);
  localparam int unsigned STEP = PER / NCH;

  state_e          state;
  logic [BWID-1:0] cnt;
  logic [BWID-1:0] data [NCH-1:0];
  logic [BWID-1:0] rng  [NCH-1:0];
  logic [BWID-1:0] thr  [NCH-1:0];
  logic            cnt_last;
  logic            load;

  for (genvar k = 0; k < NCH; k++) begin : g_rng
    unary_rng_sobol1d #(
      .BWID (BWID),
      .OFST (k * STEP)
    ) u_rng (
      .cnt (cnt),
      .rng (rng[k])
    );
  end

`ifdef UBSG_BIPOLAR_EN
  // Flipping the sign bit maps signed [-2^(BWID-1), 2^(BWID-1)) onto the
  // unsigned ones count [0, 2^BWID).
  localparam logic [BWID-1:0] HALF = BWID'(1) << (BWID - 1);
  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      thr[k] = data[k] ^ HALF;
    end
  end
`else
  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      thr[k] = data[k];
    end
  end
`endif

  always_comb begin
    cnt_last = (cnt == '1);
    i_ready  = (state == IDLE) || ((state == RUN) && i_en && cnt_last);
    load     = i_valid && i_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_done  <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        data[k]  <= '0;
        o_bit[k] <= 1'b0;
      end
    end else begin
      // o_last is visible in the cycle after the final edge; if the FSM is
      // already back in IDLE then, no reload happened.
      o_done <= o_last && (state == IDLE);
      case (state)
        IDLE: begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          for (int unsigned k = 0; k < NCH; k++) begin
            o_bit[k] <= 1'b0;
          end
          if (load) begin
            state <= RUN;
            cnt   <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin
              data[k] <= i_data[k];
            end
          end
        end
        RUN: begin
          if (i_en) begin
            cnt     <= cnt + BWID'(1);
            o_valid <= 1'b1;
            o_last  <= cnt_last;
            for (int unsigned k = 0; k < NCH; k++) begin
              o_bit[k] <= (thr[k] > rng[k]);
            end
            if (cnt_last) begin
              if (load) begin
                // Reload on the final cycle keeps the stream gapless; the
                // bit above still uses the outgoing data.
                cnt <= '0;
                for (int unsigned k = 0; k < NCH; k++) begin
                  data[k] <= i_data[k];
                end
              end else begin
                state <= IDLE;
              end
            end
          end else begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            for (int unsigned k = 0; k < NCH; k++) begin
              o_bit[k] <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
